// File: rtl/counter_16.sv
// counter_16: WIDTH-bit registered up-counter advanced by the inc qualifier.
// Optional macro COUNTER16_INC_EDGE_EN counts rising edges of inc instead of its level.
module counter_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic             qual;
  logic [WIDTH-1:0] count_nxt;

`ifdef COUNTER16_INC_EDGE_EN
  // Previous-cycle copy of inc; cleared by reset so an edge during reset is dropped.
  logic inc_d;

  always_ff @(posedge clk) begin
    if (resetn) begin
      inc_d <= 1'b0;
    end else begin
      inc_d <= inc;
    end
  end

  assign qual = inc & ~inc_d;
`else
  assign qual = inc;
`endif

  // Next-count selection; wraps naturally modulo 2^WIDTH.
  always_comb begin
    count_nxt = count;
    if (qual) begin
      count_nxt = count + WIDTH'(1);
    end
  end

  // Synchronous active-high reset has priority over counting.
  always_ff @(posedge clk) begin
    if (resetn) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_counter_16.sv
// Scoreboard bench for counter_16: driver pushes model results, monitor pops and compares.
// Honours COUNTER16_INC_EDGE_EN so the model matches either build.
module tb_counter_16;

  localparam int unsigned WIDTH = 16;
  localparam int          MODV  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             resetn;
  logic             inc;
  logic [WIDTH-1:0] count;

  logic [WIDTH-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               model    = 0;
  bit               prev_inc = 1'b0;

  counter_16 #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .inc    (inc),
    .count  (count)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus and predict the count seen after the next rising edge.
  task automatic step(input bit r, input bit i);
    bit q;
    @(negedge clk);
    resetn = r;
    inc    = i;
`ifdef COUNTER16_INC_EDGE_EN
    q        = i && !prev_inc;
    prev_inc = r ? 1'b0 : i;
`else
    q = i;
`endif
    if (r) begin
      model = 0;
    end else if (q) begin
      model = (model + 1) % MODV;
    end
    exp_q.push_back(WIDTH'(model));
  endtask

  // Direct check against a hand-derived constant, sampled after the edge that follows the last step.
  task automatic check_now(input string name, input logic [WIDTH-1:0] want);
    @(posedge clk);
    #2;
    n_checks++;
    if (count !== want) begin
      n_fail++;
      $display("FAIL %s: count=%h expected=%h at %0t", name, count, want, $time);
    end
  endtask

  // Advance the count by n using whichever inc pattern the build counts.
  task automatic count_up(input int n);
    for (int k = 0; k < n; k++) begin
`ifdef COUNTER16_INC_EDGE_EN
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
`else
      step(1'b0, 1'b1);
`endif
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a fresh count.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (count !== e) begin
          n_fail++;
          $display("FAIL scoreboard: count=%h expected=%h at %0t", count, e, $time);
        end
      end
    end
  end

  initial begin
    resetn = 1'b1;
    inc    = 1'b0;

    // Reset held with inc toggling, then idle.
    for (int k = 0; k < 3; k++) step(1'b1, 1'(k % 2));
    check_now("reset_hold", 16'h0000);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_now("idle_after_reset", 16'h0000);

    // Level run: inc high ten cycles.
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1);
`ifdef COUNTER16_INC_EDGE_EN
    check_now("level_run", 16'h0001);
`else
    check_now("level_run", 16'h000A);
`endif
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
`ifdef COUNTER16_INC_EDGE_EN
    check_now("level_hold", 16'h0001);
`else
    check_now("level_hold", 16'h000A);
`endif

    // Toggle pattern: period 4, high 2, forty cycles from zero.
    do_reset();
    for (int k = 0; k < 40; k++) step(1'b0, 1'((k % 4) < 2));
`ifdef COUNTER16_INC_EDGE_EN
    check_now("toggle40", 16'd10);
`else
    check_now("toggle40", 16'd20);
`endif

`ifndef COUNTER16_INC_EDGE_EN
    // Wrap through 0xFFFF.
    do_reset();
    count_up(65534);
    step(1'b0, 1'b0);
    check_now("preload_fffe", 16'hFFFE);
    step(1'b0, 1'b1);
    check_now("wrap_ffff", 16'hFFFF);
    step(1'b0, 1'b1);
    check_now("wrap_0000", 16'h0000);
    step(1'b0, 1'b1);
    check_now("wrap_0001", 16'h0001);
`endif

    // Reset mid-count with inc high, then resume.
    do_reset();
    count_up(291);
    step(1'b0, 1'b0);
    check_now("preload_0123", 16'h0123);
    step(1'b1, 1'b1);
    check_now("mid_reset", 16'h0000);
    step(1'b0, 1'b1);
    check_now("resume", 16'h0001);

`ifdef COUNTER16_INC_EDGE_EN
    // Long high pulse counts once.
    do_reset();
    count_up(5);
    for (int k = 0; k < 50; k++) step(1'b0, 1'b1);
    check_now("edge_hold", 16'h0006);
`endif

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 2000; k++) begin
      step(1'($urandom_range(31) == 0), 1'($urandom_range(1)));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
